// File: rtl/bit_serializer_if.sv
// Parallel word channel into the serializer: valid/ready handshake carrying one WIDTH-bit word.
// The upstream source drives it through master; the serializer consumes it through slave.
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;

  modport master (
    output din,
    output din_valid,
    input  din_ready
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready
  );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: words accepted over valid/ready leave MSB-first, one bit per shift_en.
// Optional trailing even-parity bit when SERIALIZER_PARITY_EN is defined; idle level held between frames.
module bit_serializer #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  bit_serializer_if.slave  word_if,
  input  logic             shift_en,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             frame_done
);

`ifdef SERIALIZER_PARITY_EN
  localparam int FRAME_BITS = WIDTH + 1;
`else
  localparam int FRAME_BITS = WIDTH;
`endif
  localparam int                CNT_W    = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_BITS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                state, state_nxt;
  logic [FRAME_BITS-1:0] sr, sr_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  bit_q, bit_nxt;
  logic                  done_q, done_nxt;

  logic                  last_bit;
  logic                  accept;
  logic [FRAME_BITS-1:0] load_word;

`ifdef SERIALIZER_PARITY_EN
  // Parity is fixed at accept time so later din changes cannot disturb it.
  assign load_word = {word_if.din, ^word_if.din};
`else
  assign load_word = word_if.din;
`endif

  assign last_bit          = (state == SHIFT) && shift_en && (cnt == LAST_CNT);
  assign word_if.din_ready = reset && ((state == IDLE) || last_bit);
  assign accept            = word_if.din_valid && word_if.din_ready;

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    bit_nxt   = bit_q;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SHIFT;
          sr_nxt    = load_word;
          cnt_nxt   = '0;
          bit_nxt   = load_word[FRAME_BITS-1];
        end
      end

      SHIFT: begin
        if (shift_en) begin
          if (cnt == LAST_CNT) begin
            done_nxt = 1'b1;
            // Reloading on the last bit keeps back-to-back frames gapless.
            if (accept) begin
              sr_nxt  = load_word;
              cnt_nxt = '0;
              bit_nxt = load_word[FRAME_BITS-1];
            end else begin
              state_nxt = IDLE;
              sr_nxt    = '0;
              cnt_nxt   = '0;
              bit_nxt   = IDLE_BIT;
            end
          end else begin
            sr_nxt  = sr << 1;
            cnt_nxt = cnt + CNT_W'(1);
            bit_nxt = sr[FRAME_BITS-2];
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        sr_nxt    = '0;
        cnt_nxt   = '0;
        bit_nxt   = IDLE_BIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      sr     <= '0;
      cnt    <= '0;
      bit_q  <= IDLE_BIT;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      sr     <= sr_nxt;
      cnt    <= cnt_nxt;
      bit_q  <= bit_nxt;
      done_q <= done_nxt;
    end
  end

  assign bit_out    = bit_q;
  assign bit_valid  = (state == SHIFT);
  assign busy       = (state == SHIFT);
  assign frame_done = done_q;

endmodule
